// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per clock, N = WIDTH/2+1 digits,
// with per-operand signed/unsigned selection and valid/ready handshakes on both sides.

module booth_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   b_i,
    input  logic               unsigned_i,
    output logic [WIDTH/2:0]   is_zero_o,
    output logic [WIDTH/2:0]   is_pos_one_o,
    output logic [WIDTH/2:0]   is_pos_double_o,
    output logic [WIDTH/2:0]   is_neg_one_o,
    output logic [WIDTH/2:0]   is_neg_double_o
);
    localparam int N = WIDTH / 2 + 1;

    logic             extBit;
    logic [WIDTH+2:0] bExt;

    // Two extension bits make the top digit see a non-negative value for unsigned operands.
    assign extBit = unsigned_i ? 1'b0 : b_i[WIDTH-1];
    assign bExt   = {extBit, extBit, b_i, 1'b0};

    for (genvar k = 0; k < N; k++) begin : g_digit
        logic [2:0] trip;
        assign trip               = bExt[2*k+2 -: 3];
        assign is_zero_o[k]       = (trip == 3'b000) || (trip == 3'b111);
        assign is_pos_one_o[k]    = (trip == 3'b001) || (trip == 3'b010);
        assign is_pos_double_o[k] = (trip == 3'b011);
        assign is_neg_double_o[k] = (trip == 3'b100);
        assign is_neg_one_o[k]    = (trip == 3'b101) || (trip == 3'b110);
    end
endmodule

module booth_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 a_unsigned_i,
    input  logic                 b_unsigned_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   aLat_q, bLat_q;
    logic               aUns_q, bUns_q;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic               inReady_q, outValid_q;
    logic [2*WIDTH-1:0] product_q;

    logic [N-1:0]       isZero, isPosOne, isPosDouble, isNegOne, isNegDouble;
    logic               aSign;
    logic [WIDTH+1:0]   aExt;
    logic [AW-1:0]      ppMag, pp;

`ifdef COMM_ASSERT
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $fatal(1, "booth_mul_iter: WIDTH must be even and >= 4");
    end
`endif

    booth_radix4 #(.WIDTH(WIDTH)) u_enc (
        .b_i             (bLat_q),
        .unsigned_i      (bUns_q),
        .is_zero_o       (isZero),
        .is_pos_one_o    (isPosOne),
        .is_pos_double_o (isPosDouble),
        .is_neg_one_o    (isNegOne),
        .is_neg_double_o (isNegDouble)
    );

    assign aSign = aUns_q ? 1'b0 : aLat_q[WIDTH-1];
    assign aExt  = {aSign, aSign, aLat_q};

    // Select the current digit's multiple of A, then weight it by 4^cnt before accumulating.
    always_comb begin
        ppMag = {{(AW-WIDTH-2){aExt[WIDTH+1]}}, aExt};
        pp    = '0;
        if (isZero[cnt_q])
            pp = '0;
        else if (isPosOne[cnt_q])
            pp = ppMag;
        else if (isPosDouble[cnt_q])
            pp = ppMag << 1;
        else if (isNegOne[cnt_q])
            pp = -ppMag;
        else if (isNegDouble[cnt_q])
            pp = -(ppMag << 1);
        acc_d = acc_q + (pp << {cnt_q, 1'b0});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            aLat_q     <= '0;
            bLat_q     <= '0;
            aUns_q     <= 1'b0;
            bUns_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            product_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        aLat_q    <= a_i;
                        bLat_q    <= b_i;
                        aUns_q    <= a_unsigned_i;
                        bUns_q    <= b_unsigned_i;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        product_q  <= acc_d[2*WIDTH-1:0];
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COMM_ASSERT
    for (genvar k = 0; k < N; k++) begin : g_onehot
        always_ff @(posedge clk_i) begin
            if (rst_ni)
                assert ($onehot({isZero[k], isPosOne[k], isPosDouble[k], isNegOne[k], isNegDouble[k]}))
                else $error("booth_mul_iter: digit %0d flags not one-hot", k);
        end
    end
`endif

    assign in_ready_o  = inReady_q;
    assign out_valid_o = outValid_q;
    assign product_o   = product_q;
endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench for booth_mul_iter at WIDTH=8 and WIDTH=16 against an integer reference product.

module tb_booth_mul_iter;
    localparam int N8  = 5;
    localparam int N16 = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid, aUns, bUns, outReady, inReady, outValid;
    logic [7:0]  aIn, bIn;
    logic [15:0] product;
    logic        inValid16, aUns16, bUns16, inReady16, outValid16;
    logic [15:0] aIn16, bIn16;
    logic [31:0] product16;

    int tests = 0;
    int failures = 0;
    int cycle = 0;

    logic [15:0] expQ8[$];
    int          accQ8[$];
    logic [31:0] expQ16[$];
    int          accQ16[$];

    booth_mul_iter #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValid), .in_ready_o(inReady),
        .a_i(aIn), .b_i(bIn), .a_unsigned_i(aUns), .b_unsigned_i(bUns),
        .out_valid_o(outValid), .out_ready_i(outReady), .product_o(product)
    );

    booth_mul_iter #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValid16), .in_ready_o(inReady16),
        .a_i(aIn16), .b_i(bIn16), .a_unsigned_i(aUns16), .b_unsigned_i(bUns16),
        .out_valid_o(outValid16), .out_ready_i(outReady), .product_o(product16)
    );

    // Free-running clock and an edge counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact mathematical product of the operands as interpreted by their signedness flags.
    function automatic logic [31:0] refMul(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input bit au, input bit bu);
        longint m, av, bv, p;
        m  = longint'(1) << w;
        av = longint'(a) & (m - 1);
        bv = longint'(b) & (m - 1);
        if (!au && a[w-1]) av = av - m;
        if (!bu && b[w-1]) bv = bv - m;
        p = av * bv;
        return p[31:0];
    endfunction

    function automatic logic [15:0] pickOperand(input int w);
        logic [15:0] r;
        logic [15:0] msb;
        msb = 16'(1) << (w - 1);
        r   = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r = '0;
            1: r = '1;
            2: r = msb;
            3: r = msb - 16'd1;
            4: r = 16'd1;
            default: ;
        endcase
        if (w == 8) r[15:8] = '0;
        return r;
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit au, input bit bu);
        int waitCyc;
        logic [31:0] e;
        @(negedge clk);
        aIn = a; bIn = b; aUns = au; bUns = bu; inValid = 1'b1;
        waitCyc = 0;
        while (!inReady && waitCyc < 60) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!inReady) begin
            checkOutput("accept8", 32'(inReady), 32'd1);
            inValid = 1'b0;
            return;
        end
        e = refMul(8, {8'h00, a}, {8'h00, b}, au, bu);
        expQ8.push_back(e[15:0]);
        accQ8.push_back(cycle + 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        aIn = 8'($urandom); bIn = 8'($urandom); aUns = 1'($urandom); bUns = 1'($urandom);
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input bit au, input bit bu);
        int waitCyc;
        @(negedge clk);
        aIn16 = a; bIn16 = b; aUns16 = au; bUns16 = bu; inValid16 = 1'b1;
        waitCyc = 0;
        while (!inReady16 && waitCyc < 60) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!inReady16) begin
            checkOutput("accept16", 32'(inReady16), 32'd1);
            inValid16 = 1'b0;
            return;
        end
        expQ16.push_back(refMul(16, a, b, au, bu));
        accQ16.push_back(cycle + 1);
        @(posedge clk);
        #1;
        inValid16 = 1'b0;
        aIn16 = 16'($urandom); bIn16 = 16'($urandom);
    endtask

    // Monitors: pop on each rising out_valid, then watch the product hold until it drops.
    bit          prev8 = 1'b0;
    logic [15:0] held8;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev8 = 1'b0;
        end else if (outValid) begin
            if (!prev8) begin
                if (expQ8.size() == 0) begin
                    checkOutput("unexpected8", 32'(expQ8.size()), 32'd1);
                end else begin
                    checkOutput("product8", 32'(product), 32'(expQ8.pop_front()));
                    checkOutput("latency8", 32'(cycle - accQ8.pop_front()), 32'(N8));
                end
                held8 = product;
            end else begin
                checkOutput("hold8", 32'(product), 32'(held8));
            end
            checkOutput("busyReady8", 32'(inReady), 32'd0);
            prev8 = 1'b1;
        end else begin
            prev8 = 1'b0;
        end
    end

    bit          prev16 = 1'b0;
    logic [31:0] held16;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev16 = 1'b0;
        end else if (outValid16) begin
            if (!prev16) begin
                if (expQ16.size() == 0) begin
                    checkOutput("unexpected16", 32'(expQ16.size()), 32'd1);
                end else begin
                    checkOutput("product16", product16, expQ16.pop_front());
                    checkOutput("latency16", 32'(cycle - accQ16.pop_front()), 32'(N16));
                end
                held16 = product16;
            end else begin
                checkOutput("hold16", product16, held16);
            end
            prev16 = 1'b1;
        end else begin
            prev16 = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCyc;
        logic [31:0] e;
        inValid = 1'b0; aIn = '0; bIn = '0; aUns = 1'b0; bUns = 1'b0; outReady = 1'b1;
        inValid16 = 1'b0; aIn16 = '0; bIn16 = '0; aUns16 = 1'b0; bUns16 = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstProduct", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", 32'(inReady), 32'd1);
        checkOutput("postRstOutValid", 32'(outValid), 32'd0);

        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'h81, 1'b1, 1'b0);

        // Back-pressure: second pair waits with in_valid high while the result is stalled.
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        outReady = 1'b0;
        aIn = 8'h03; bIn = 8'hFE; aUns = 1'b0; bUns = 1'b0; inValid = 1'b1;
        waitCyc = 0;
        while (!outValid && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("bpValidRise", 32'(outValid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bpValidHeld", 32'(outValid), 32'd1);
            checkOutput("bpInReady", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bpIdleReady", 32'(inReady), 32'd1);
        checkOutput("bpValidDrop", 32'(outValid), 32'd0);
        e = refMul(8, 16'h0003, 16'h00FE, 1'b0, 1'b0);
        expQ8.push_back(e[15:0]);
        accQ8.push_back(cycle + 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;

        // Abort a multiply with an asynchronous reset after two digit steps.
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        aIn = 8'h55; bIn = 8'h33; aUns = 1'b0; bUns = 1'b0; inValid = 1'b1;
        waitCyc = 0;
        while (!inReady && waitCyc < 30) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("rstOpAccept", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("abortOutValid", 32'(outValid), 32'd0);
        checkOutput("abortProduct", 32'(product), 32'd0);
        checkOutput("abortInReady", 32'(inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("relOutValid", 32'(outValid), 32'd0);
        checkOutput("relProduct", 32'(product), 32'd0);
        checkOutput("relInReady", 32'(inReady), 32'd1);
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b0);

        repeat (40) applyStimulus(8'(pickOperand(8)), 8'(pickOperand(8)), 1'($urandom), 1'($urandom));
        repeat (30) applyStimulus16(pickOperand(16), pickOperand(16), 1'($urandom), 1'($urandom));
        applyStimulus16(16'h8000, 16'h8000, 1'b0, 1'b0);
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

        waitCyc = 0;
        while ((expQ8.size() != 0 || expQ16.size() != 0) && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("drain8", 32'(expQ8.size()), 32'd0);
        checkOutput("drain16", 32'(expQ16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
